// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: byte FIFO over a single-port SRAM region with exclusive read/write access
module sram_fifo_ctrl #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 flush,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 rd_ready,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 sram_read_enable,
  output logic                 sram_write_enable,
  output logic [ADDR_BITS-1:0] sram_address,
  output logic [DATA_BITS-1:0] sram_write_data,
  input  logic [DATA_BITS-1:0] sram_read_data
);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  localparam logic [ADDR_BITS:0]   DEPTH_N = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST    = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] BASE    = ADDR_BITS'(BASE_ADDR);
  state_t                 state, state_nx, last_op;
  logic                   hold_valid, wr_pend, rd_pend;
  logic [DATA_BITS-1:0]   hold_data;
  logic [ADDR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]     mem_count;
  assign wr_ready = !hold_valid && mem_count < DEPTH_N;
  assign count    = mem_count;
  assign full     = mem_count == DEPTH_N;
  assign empty    = mem_count == '0;
  // state register; last_op remembers the most recent SRAM access for round-robin
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state   <= IDLE;
      last_op <= RD;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
      if (state_nx != IDLE) last_op <= state_nx;
    end
  // next-state: serve whichever side is pending, alternating when both are
  always_comb begin
    wr_pend  = hold_valid && state != WR;
    rd_pend  = mem_count != '0 && !rd_valid && state != RD;
    state_nx = wr_pend && rd_pend ? (last_op == WR ? RD : WR) :
               wr_pend ? WR : rd_pend ? RD : IDLE;
  end
  // SRAM port decoded from state and registers only
  always_comb begin
    sram_write_enable = state == WR;
    sram_read_enable  = state == RD;
    sram_address      = state == WR ? BASE + wr_ptr : state == RD ? BASE + rd_ptr : '0;
    sram_write_data   = state == WR ? hold_data : '0;
  end
  // datapath: holding register, pointers, occupancy and output register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      rd_valid   <= 1'b0;
    end else begin
      if (wr_valid && wr_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= wr_data;
      end
      if (state == WR) begin
        hold_valid <= 1'b0;
        wr_ptr     <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
        mem_count  <= mem_count + 1'b1;
      end
      if (state == RD) begin
        rd_data   <= sram_read_data;
        rd_valid  <= 1'b1;
        rd_ptr    <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
        mem_count <= mem_count - 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed checks of sram_fifo_ctrl against an SRAM model
module tb_sram_fifo_ctrl;
  logic        clk = 0, n_rst = 1, flush = 0;
  logic        wr_valid [2], wr_ready [2], rd_valid [2], rd_ready [2];
  logic [7:0]  wr_data [2], rd_data [2], wdata [2], rdata [2];
  logic [16:0] count [2];
  logic        full [2], empty [2], re [2], we [2];
  logic [15:0] addr [2];
  logic [7:0]  mem [2][65536];
  logic [23:0] wl [2][128];
  int          wn [2] = '{0, 0};
  int          rcnt [2] = '{0, 0};
  logic        excl_bad = 0;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_fifo_ctrl #(.ADDR_BITS(16), .DATA_BITS(8), .BASE_ADDR(g ? 'hFFFE : 0), .DEPTH(g ? 2 : 4)) u_dut (
      .clk(clk), .n_rst(n_rst), .flush(flush),
      .wr_valid(wr_valid[g]), .wr_data(wr_data[g]), .wr_ready(wr_ready[g]),
      .rd_valid(rd_valid[g]), .rd_data(rd_data[g]), .rd_ready(rd_ready[g]),
      .count(count[g]), .full(full[g]), .empty(empty[g]),
      .sram_read_enable(re[g]), .sram_write_enable(we[g]),
      .sram_address(addr[g]), .sram_write_data(wdata[g]), .sram_read_data(rdata[g]));
  end
  assign rdata[0] = mem[0][addr[0]];
  assign rdata[1] = mem[1][addr[1]];
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (we[k]) begin
        mem[k][addr[k]] <= wdata[k];
        if (wn[k] < 128) wl[k][wn[k]] <= {addr[k], wdata[k]};
        wn[k] <= wn[k] + 1;
      end
      if (re[k]) rcnt[k] <= rcnt[k] + 1;
    end
  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (re[k] && we[k]) excl_bad <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d);
    int n = 0;
    logic ok;
    wr_valid[k] = 1;
    wr_data[k] = d;
    do begin
      @(negedge clk);
      ok = wr_ready[k];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    wr_valid[k] = 0;
    check("push_hs", ok, 1);
  endtask

  task automatic pop(input int k, output logic [7:0] d);
    int n = 0;
    logic ok;
    rd_ready[k] = 1;
    do begin
      @(negedge clk);
      ok = rd_valid[k];
      d = rd_data[k];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    rd_ready[k] = 0;
    check("pop_hs", ok, 1);
  endtask

  initial begin
    logic [7:0] d;
    int b, r;
    for (int k = 0; k < 2; k++) begin
      wr_valid[k] = 0;
      wr_data[k] = 0;
      rd_ready[k] = 0;
    end
    #2 n_rst = 0;
    #1;
    check("rst_rd_valid", rd_valid[0], 0);
    check("rst_rd_data", rd_data[0], 0);
    check("rst_count", count[0], 0);
    check("rst_empty", empty[0], 1);
    check("rst_full", full[0], 0);
    check("rst_wr_ready", wr_ready[0], 1);
    check("rst_re", re[0], 0);
    check("rst_we", we[0], 0);
    check("rst_addr", addr[0], 0);
    check("rst_wdata", wdata[0], 0);
    @(negedge clk) n_rst = 1;
    tick(1);
    push(0, 8'hAA);
    tick(1);
    check("mid_wr_we", we[0], 1);
    #2 n_rst = 0;
    #1;
    check("midrst_we", we[0], 0);
    check("midrst_count", count[0], 0);
    check("midrst_wr_ready", wr_ready[0], 1);
    check("midrst_addr", addr[0], 0);
    @(negedge clk) n_rst = 1;
    tick(1);
    b = wn[0];
    push(0, 8'hFF);
    push(0, 8'h05);
    tick(8);
    check("wr0", wl[0][b], {16'h0000, 8'hFF});
    check("wr1", wl[0][b+1], {16'h0001, 8'h05});
    check("two_rd_valid", rd_valid[0], 1);
    check("two_rd_data", rd_data[0], 8'hFF);
    check("two_count", count[0], 1);
    pop(0, d);
    check("pop0", d, 8'hFF);
    pop(0, d);
    check("pop1", d, 8'h05);
    check("drained_empty", empty[0], 1);
    check("drained_rd_valid", rd_valid[0], 0);
    r = rcnt[0];
    rd_ready[0] = 1;
    tick(10);
    rd_ready[0] = 0;
    check("empty_no_read", rcnt[0] - r, 0);
    check("empty_rd_valid", rd_valid[0], 0);
    @(negedge clk) n_rst = 0;
    @(negedge clk) n_rst = 1;
    tick(1);
    b = wn[0];
    fork
      for (int i = 0; i < 8; i++) push(0, 8'hA0 + 8'(i));
      begin
        logic [7:0] q;
        tick(30);
        check("full_flag", full[0], 1);
        check("full_wr_ready", wr_ready[0], 0);
        check("full_count", count[0], 4);
        check("wr_a3", wl[0][b+3], {16'h0003, 8'hA3});
        check("wr_wrap", wl[0][b+4], {16'h0000, 8'hA4});
        for (int i = 0; i < 8; i++) begin
          pop(0, q);
          check("full_order", q, 8'hA0 + 8'(i));
        end
        check("wr_after_pop", wl[0][b+5], {16'h0001, 8'hA5});
      end
    join
    fork
      for (int i = 1; i <= 20; i++) push(0, 8'(i));
      begin
        logic [7:0] q;
        for (int i = 1; i <= 20; i++) begin
          pop(0, q);
          check("stream", q, 8'(i));
        end
      end
    join
    for (int i = 0; i < 5; i++) push(0, 8'h30 + 8'(i));
    check("pre_flush_count", count[0], 3);
    check("pre_flush_wr_ready", wr_ready[0], 0);
    flush = 1;
    tick(1);
    flush = 0;
    check("flush_count", count[0], 0);
    check("flush_rd_valid", rd_valid[0], 0);
    check("flush_wr_ready", wr_ready[0], 1);
    check("flush_empty", empty[0], 1);
    b = wn[0];
    push(0, 8'h77);
    tick(4);
    check("flush_wr_addr", wl[0][b], {16'h0000, 8'h77});
    pop(0, d);
    check("flush_pop", d, 8'h77);
    b = wn[1];
    push(1, 8'hC0);
    push(1, 8'hC1);
    push(1, 8'hC2);
    tick(6);
    check("hi_wr0", wl[1][b], {16'hFFFE, 8'hC0});
    check("hi_wr1", wl[1][b+1], {16'hFFFF, 8'hC1});
    check("hi_wr2", wl[1][b+2], {16'hFFFE, 8'hC2});
    check("hi_full", full[1], 1);
    for (int i = 0; i < 3; i++) begin
      pop(1, d);
      check("hi_order", d, 8'hC0 + 8'(i));
    end
    check("excl", excl_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
